// File: rtl/stprx_pkg.sv
// Shared types and constants for the stp_rx step/direction receiver.
package stprx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVING = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // Full-step coil patterns packed low index first: 0011, 0110, 1100, 1001.
  localparam logic [15:0] PHASE_TBL = {4'b1001, 4'b1100, 4'b0110, 4'b0011};

  localparam int MAX_POS_DEF    = 240;
  localparam int SETTLE_CYC_DEF = 8;
  localparam int OFF_CYC_DEF    = 64;

  function automatic logic [3:0] phase_of(input logic [1:0] idx);
    return PHASE_TBL[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/stp_rx_if.sv
// Motor-side step/direction inputs, coil drive and position report handshake.
// master: the receiver (drives phase/report); slave: controller/system side.
interface stp_rx_if;
  logic       dir_i;
  logic       pulse_i;
  logic [3:0] phase_o;
  logic [7:0] pos_o;
  logic       valid_o;
  logic       ack_i;
  logic       err_o;

  modport master (
    input  dir_i, pulse_i, ack_i,
    output phase_o, pos_o, valid_o, err_o
  );

  modport slave (
    output dir_i, pulse_i, ack_i,
    input  phase_o, pos_o, valid_o, err_o
  );
endinterface

// File: rtl/stprx_sync.sv
// Two-flop synchronisers for the asynchronous dir/pulse inputs plus a
// rising-edge detector on the synchronised pulse. step is a one-cycle strobe;
// dir_s is aligned with it.
module stprx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic dir_i,
  input  logic pulse_i,
  output logic step,
  output logic dir_s
);

  logic dir_ff1, dir_ff2;
  logic pulse_ff1, pulse_ff2, pulse_d;

  // Synchronise both inputs and keep one delayed copy of pulse for edge detect.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dir_ff1   <= 1'b0;
      dir_ff2   <= 1'b0;
      pulse_ff1 <= 1'b0;
      pulse_ff2 <= 1'b0;
      pulse_d   <= 1'b0;
    end else begin
      dir_ff1   <= dir_i;
      dir_ff2   <= dir_ff1;
      pulse_ff1 <= pulse_i;
      pulse_ff2 <= pulse_ff1;
      pulse_d   <= pulse_ff2;
    end
  end

  assign step  = pulse_ff2 & ~pulse_d;
  assign dir_s = dir_ff2;

endmodule

// File: rtl/stp_rx.sv
// Step/direction receiver: tracks absolute position, drives full-step coil
// pattern, reports the settled position over valid/ack.
// Optional coil de-energise after idle: define STPRX_COIL_OFF_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no motion, no report pending
// ST_MOVING | steps seen recently; waiting SETTLE_CYC quiet cycles
// ST_REPORT | pos_o/valid_o presented, waiting for ack_i
module stp_rx
  import stprx_pkg::*;
#(
  parameter int MAX_POS    = MAX_POS_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
`ifdef STPRX_COIL_OFF_EN
  ,
  parameter int OFF_CYC    = OFF_CYC_DEF
`endif
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  stp_rx_if.master  bus
);

  localparam logic [7:0] MAX_P       = 8'(MAX_POS);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  logic       step, dir_s;
  logic [7:0] pos_q, pos_nxt, rep_pos_q;
  logic [3:0] phase_q;
  logic       limit_hit, valid_q, err_q, dirty_q, dirty_d;
  logic [7:0] cnt_q, cnt_d;
  logic       load_rep, drop_rep;
  state_t     state_q, state_d;

  stprx_sync u_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .dir_i   (bus.dir_i),
    .pulse_i (bus.pulse_i),
    .step    (step),
    .dir_s   (dir_s)
  );

  assign limit_hit = dir_s ? (pos_q == 8'd0) : (pos_q == MAX_P);
  assign pos_nxt   = dir_s ? (pos_q - 8'd1) : (pos_q + 8'd1);

  // Position and coil pattern move together; a blocked step changes neither.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q   <= 8'd0;
      phase_q <= 4'b0011;
    end else if (step && !limit_hit) begin
      pos_q   <= pos_nxt;
      phase_q <= phase_of(pos_nxt[1:0]);
    end
  end

  // Sticky limit error; a new violation wins over the clearing acknowledge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (step && limit_hit) begin
      err_q <= 1'b1;
    end else if (valid_q && bus.ack_i) begin
      err_q <= 1'b0;
    end
  end

  // Next-state, settle counter and dirty-flag logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dirty_d  = dirty_q;
    load_rep = 1'b0;
    drop_rep = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (step) begin
          state_d = ST_MOVING;
          cnt_d   = 8'd0;
        end
      end
      ST_MOVING: begin
        if (step) begin
          cnt_d = 8'd0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d  = ST_REPORT;
          load_rep = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_REPORT: begin
        if (bus.ack_i) begin
          drop_rep = 1'b1;
          dirty_d  = 1'b0;
          cnt_d    = 8'd0;
          state_d  = (dirty_q || step) ? ST_MOVING : ST_IDLE;
        end else if (step) begin
          dirty_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register plus the held report outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      dirty_q   <= 1'b0;
      valid_q   <= 1'b0;
      rep_pos_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dirty_q <= dirty_d;
      if (load_rep) begin
        rep_pos_q <= pos_q;
        valid_q   <= 1'b1;
      end else if (drop_rep) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef STPRX_COIL_OFF_EN
  localparam logic [15:0] OFF_LAST = 16'(OFF_CYC - 1);
  logic [15:0] idle_cnt_q;
  logic        off_q;

  // Count consecutive idle cycles; de-energise after OFF_CYC, any step re-arms.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_cnt_q <= 16'd0;
      off_q      <= 1'b0;
    end else if (step) begin
      idle_cnt_q <= 16'd0;
      off_q      <= 1'b0;
    end else if (state_q != ST_IDLE) begin
      idle_cnt_q <= 16'd0;
    end else if (!off_q) begin
      if (idle_cnt_q == OFF_LAST) begin
        off_q <= 1'b1;
      end else begin
        idle_cnt_q <= idle_cnt_q + 16'd1;
      end
    end
  end

  assign bus.phase_o = off_q ? 4'b0000 : phase_q;
`else
  assign bus.phase_o = phase_q;
`endif

  assign bus.pos_o   = rep_pos_q;
  assign bus.valid_o = valid_q;
  assign bus.err_o   = err_q;

endmodule

// File: tb/tb_stp_rx.sv
// Directed + randomized bench for stp_rx against a plain position model.
module tb_stp_rx;
  import stprx_pkg::*;

  localparam int MAX_POS    = 240;
  localparam int SETTLE_CYC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stp_rx_if bus();

  stp_rx #(.MAX_POS(MAX_POS), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;
  int m_pos = 0;
  bit m_err = 1'b0;

  function automatic logic [31:0] exp_phase(input int p);
    case (p % 4)
      0: return 32'b0011;
      1: return 32'b0110;
      2: return 32'b1100;
      default: return 32'b1001;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One pulse: dir set a cycle ahead, pulse high one cycle, then low.
  task automatic do_step(input bit d);
    @(negedge clk) bus.dir_i = d;
    @(negedge clk) bus.pulse_i = 1'b1;
    @(negedge clk) bus.pulse_i = 1'b0;
    if (!d) begin
      if (m_pos == MAX_POS) m_err = 1'b1; else m_pos++;
    end else begin
      if (m_pos == 0) m_err = 1'b1; else m_pos--;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (bus.valid_o !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("valid_timeout", 32'(bus.valid_o), 32'd1);
  endtask

  task automatic check_report(input string tag);
    int n;
    wait_valid(n);
    chk({tag, "_pos"}, 32'(bus.pos_o), 32'(m_pos));
    chk({tag, "_phase"}, 32'(bus.phase_o), exp_phase(m_pos));
    chk({tag, "_err"}, 32'(bus.err_o), 32'(m_err));
  endtask

  task automatic do_ack(input string tag);
    bus.ack_i = 1'b1;
    @(negedge clk) bus.ack_i = 1'b0;
    m_err = 1'b0;
    chk({tag, "_ack_valid"}, 32'(bus.valid_o), 32'd0);
    chk({tag, "_ack_err"}, 32'(bus.err_o), 32'(m_err));
  endtask

  initial begin
    int n;
    bus.dir_i = 1'b0;
    bus.pulse_i = 1'b0;
    bus.ack_i = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_pos", 32'(bus.pos_o), 32'd0);
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_phase", 32'(bus.phase_o), 32'b0011);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Forward move of five steps, with report latency measured.
    repeat (5) do_step(1'b0);
    wait_valid(n);
    chk("fwd_latency", 32'(n), 32'(SETTLE_CYC + 2));
    chk("fwd_pos", 32'(bus.pos_o), 32'd5);
    chk("fwd_phase", 32'(bus.phase_o), 32'b0110);
    chk("fwd_err", 32'(bus.err_o), 32'd0);
    repeat (3) @(negedge clk);
    chk("fwd_hold_valid", 32'(bus.valid_o), 32'd1);
    chk("fwd_hold_pos", 32'(bus.pos_o), 32'd5);
    do_ack("fwd");
    chk("fwd_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    repeat (12) @(negedge clk);
    chk("fwd_no_rereport", 32'(bus.valid_o), 32'd0);

    // Asynchronous reset while the clock is high.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pos", 32'(bus.pos_o), 32'd0);
    chk("arst_valid", 32'(bus.valid_o), 32'd0);
    chk("arst_phase", 32'(bus.phase_o), 32'b0011);
    chk("arst_err", 32'(bus.err_o), 32'd0);
    m_pos = 0;
    m_err = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // Reverse move into the lower limit.
    repeat (2) do_step(1'b0);
    check_report("pos2");
    do_ack("pos2");
    repeat (4) do_step(1'b1);
    check_report("lower");
    chk("lower_err_set", 32'(bus.err_o), 32'd1);
    do_ack("lower");

    // Idle period: coils drop only when the coil-off feature is built in.
    repeat (3) do_step(1'b0);
    check_report("pos3");
    do_ack("pos3");
    repeat (70) @(negedge clk);
`ifdef STPRX_COIL_OFF_EN
    chk("idle_phase", 32'(bus.phase_o), 32'b0000);
`else
    chk("idle_phase", 32'(bus.phase_o), exp_phase(3));
`endif
    do_step(1'b0);
    repeat (2) @(negedge clk);
    chk("wake_phase", 32'(bus.phase_o), 32'b0011);
    check_report("pos4");
    do_ack("pos4");

    // Random bursts against the model.
    for (int b = 0; b < 16; b++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int s = 0; s < len; s++) do_step(1'($urandom_range(0, 1)));
      check_report("rnd");
      do_ack("rnd");
    end

    // Step arriving while a report is pending.
    while (m_pos < 10) do_step(1'b0);
    while (m_pos > 10) do_step(1'b1);
    check_report("pre_dirty");
    do_step(1'b0);
    repeat (2) @(negedge clk);
    chk("dirty_hold_pos", 32'(bus.pos_o), 32'd10);
    chk("dirty_hold_valid", 32'(bus.valid_o), 32'd1);
    chk("dirty_phase", 32'(bus.phase_o), exp_phase(11));
    do_ack("dirty");
    chk("dirty_state_moving", 32'(dut.state_q), 32'(ST_MOVING));
    check_report("post_dirty");
    chk("post_dirty_pos11", 32'(bus.pos_o), 32'd11);
    do_ack("post_dirty");

    // Upper limit, and ack while no report is pending is ignored.
    while (m_pos < MAX_POS) do_step(1'b0);
    check_report("top");
    do_ack("top");
    do_step(1'b0);
    repeat (2) @(negedge clk);
    bus.ack_i = 1'b1;
    @(negedge clk) bus.ack_i = 1'b0;
    chk("stray_ack_err", 32'(bus.err_o), 32'd1);
    chk("stray_ack_valid", 32'(bus.valid_o), 32'd0);
    check_report("upper");
    chk("upper_pos", 32'(bus.pos_o), 32'(MAX_POS));
    chk("upper_phase", 32'(bus.phase_o), exp_phase(MAX_POS));
    chk("upper_err", 32'(bus.err_o), 32'd1);
    do_ack("upper");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
